imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of instruction memory: receives a byte stream over a valid/ready handshake and assembles 32-bit big-endian words.
- Writes each word into instruction memory through its write port (write enable, address, data-in) while holding the instruction fetch stage stalled.
- Sits between the host/debug byte link and instruction memory.
- After a load completes, the fetch stage resumes from its current PC.

Parameters:
- BASE_ADDR, 32'd0, byte address of the first word written.
- MAX_WORDS, 1024, largest legal word count; larger header counts are rejected.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load (ignored unless IDLE).
- abort  input  1  synchronous cancel; returns to IDLE next edge.
- in_valid  input  1  byte available on in_byte.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader accepts in_byte this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  32  instruction memory byte address.
- mem_data  output  32  instruction memory write data.
- cpu_hold  output  1  high while loading; fetch write_pc is gated by ~cpu_hold.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a load finishes.
- error  output  1  sticky; set on count > MAX_WORDS, cleared by next accepted start.

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - state = IDLE;
  - in_ready, mem_we, cpu_hold, busy, done, error = 0;
  - mem_addr = BASE_ADDR; mem_data = 0;
  - internal byte counter, word counter and shift register = 0.
- A byte transfer occurs on a posedge where in_valid && in_ready are both high. Byte order is most-significant first.
- States:
  - IDLE: in_ready = 0. On start: clear error, set mem_addr = BASE_ADDR, go to HDR_HI.
  - HDR_HI: in_ready = 1. On transfer, count[15:8] = in_byte; go to HDR_LO.
  - HDR_LO: in_ready = 1. On transfer, count[7:0] = in_byte, then:
    - full count == 0 -> DONE;
    - full count > MAX_WORDS -> set error, go to IDLE (no done pulse);
    - otherwise -> DATA, with words_left = count and byte index = 0.
  - DATA: in_ready = 1. On each transfer, shift in_byte into the word (first byte lands in [31:24]) and increment byte index. On the 4th byte, latch the word into mem_data and go to WRITE.
  - WRITE: in_ready = 0; mem_we = 1 for exactly this one cycle, presenting mem_addr/mem_data. Next edge:
    - mem_addr += 4 (32-bit wrap, no saturation);
    - words_left -= 1;
    - go to DONE if words_left reaches 0, else back to DATA.
  - DONE: done = 1 for one cycle; next state IDLE.
- cpu_hold = busy = (state != IDLE). The cycle the load returns to IDLE, cpu_hold drops, so fetch resumes the following edge.
- Latency: the 4th byte transfer of a word is followed by mem_we on the next cycle. The stream therefore sustains 4 bytes per 5 cycles.
- in_valid low stalls indefinitely in any receive state; no timeout.
- start while busy is ignored.
- abort has priority over every state transition including start: next state IDLE, mem_we = 0, a partially assembled word is discarded, no done pulse, error unchanged. Words already written remain in memory.
- reset_n asserted mid-load: immediate return to reset values; memory contents are not rolled back.
- mem_we is never high outside WRITE. mem_addr/mem_data hold their values between writes.

Test Plan:
- start; stream 00 02 DE AD BE EF 01 23 45 67 with in_valid always high -> mem_we pulses twice:
  - addr 0x0 data 0xDEADBEEF;
  - addr 0x4 data 0x01234567;
  - done pulses once, one cycle after the second write;
  - cpu_hold high from the cycle after start until done, then low.
- Same stream with in_valid deasserted 3 cycles between every byte -> identical writes and data, no extra mem_we, in_ready only high in receive states.
- Header 00 00 -> no mem_we, done pulses, error stays 0. Header 04 01 (1025 > MAX_WORDS) -> error = 1, no done, back to IDLE. The next start clears error.
- abort after the 2nd data byte of word 1 of a 3-word load -> one write was made (word 0); the partial word is never written; busy = 0 next cycle; no done.
- reset_n pulsed low asynchronously mid-DATA (between clock edges) -> outputs go to reset values immediately; a subsequent full load writes from BASE_ADDR again.
- BASE_ADDR = 32'hFFFFFFFC, count 2 -> writes at 0xFFFFFFFC then 0x00000000 (wrap).

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (valid/ready), assembles 32-bit
// big-endian words and writes them into instruction memory while holding
// the fetch stage stalled.
//   clk, reset_n         : clock, asynchronous active-low reset
//   start, abort         : begin a load (from IDLE) / cancel a load
//   in_valid, in_byte    : stream byte input; in_ready = byte accepted
//   mem_we/addr/data     : instruction memory write port
//   cpu_hold, busy       : high in any non-IDLE state
//   done                 : one-cycle pulse at load completion
//   error                : sticky header-count overflow flag
// Stream format: 16-bit word count (MSB first), then count*4 data bytes.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SHF_W = 24;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_DONE
  } state_t;

  state_t             state, state_d;
  logic [7:0]         count_hi;
  logic [CNT_W-1:0]   words_left;
  logic [1:0]         byte_idx;
  logic [SHF_W-1:0]   shift;

  logic               in_ready_d, mem_we_d, busy_d, done_d;
  logic               xfer;
  logic [CNT_W-1:0]   hdr_count;
  logic               count_zero, count_big;

  assign xfer       = in_valid && in_ready;
  assign hdr_count  = {count_hi, in_byte};
  assign count_zero = (hdr_count == CNT_W'(0));
  assign count_big  = (32'(hdr_count) > MAX_WORDS);

  // State register; control outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      in_ready <= in_ready_d;
      mem_we   <= mem_we_d;
      busy     <= busy_d;
      cpu_hold <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (start) state_d = S_HDR_HI;
      S_HDR_HI: if (xfer) state_d = S_HDR_LO;
      S_HDR_LO: begin
        if (xfer) begin
          if (count_zero)     state_d = S_DONE;
          else if (count_big) state_d = S_IDLE;
          else                state_d = S_DATA;
        end
      end
      S_DATA:   if (xfer && (byte_idx == 2'd3)) state_d = S_WRITE;
      S_WRITE:  state_d = (words_left == CNT_W'(1)) ? S_DONE : S_DATA;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Output decode of the upcoming state.
  always_comb begin
    in_ready_d = 1'b0;
    mem_we_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      S_HDR_HI, S_HDR_LO, S_DATA: in_ready_d = 1'b1;
      S_WRITE:                    mem_we_d   = 1'b1;
      S_DONE:                     done_d     = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Datapath: header capture, word assembly, address stepping, error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_hi   <= 8'd0;
      words_left <= '0;
      byte_idx   <= 2'd0;
      shift      <= '0;
      mem_addr   <= BASE_ADDR;
      mem_data   <= 32'd0;
      error      <= 1'b0;
    end else if (!abort) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            error    <= 1'b0;
            mem_addr <= BASE_ADDR;
          end
        end
        S_HDR_HI: if (xfer) count_hi <= in_byte;
        S_HDR_LO: begin
          if (xfer) begin
            if (count_big) begin
              error <= 1'b1;
            end else begin
              words_left <= hdr_count;
              byte_idx   <= 2'd0;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            shift    <= {shift[SHF_W-9:0], in_byte};
            byte_idx <= byte_idx + 2'd1;
            // First byte ends up in [31:24].
            if (byte_idx == 2'd3) mem_data <= {shift, in_byte};
          end
        end
        S_WRITE: begin
          mem_addr   <= mem_addr + 32'd4;
          words_left <= words_left - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load vectors plus
// hand-written abort, async-reset and address-wrap sequences. Expected
// memory writes are queued as bytes are driven and popped on mem_we.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, in_valid, en1, start1;
  logic [7:0]  in_byte;

  logic        in_ready0, mem_we0, cpu_hold0, busy0, done0, error0;
  logic [31:0] mem_addr0, mem_data0;
  logic        in_ready1, mem_we1, cpu_hold1, busy1, done1, error1;
  logic [31:0] mem_addr1, mem_data1;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;

  always #5 clk = ~clk;
  assign start1 = start & en1;

  imem_loader #(.BASE_ADDR(BASE0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready0),
    .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_data(mem_data0),
    .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .error(error0));

  imem_loader #(.BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_data(mem_data1),
    .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .error(error1));

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [15:0] cnt; int gap; int exp_done; logic exp_err; } vec_t;

  wr_t  q0[$], q1[$];
  vec_t vecs[6];
  logic [31:0] wd[4];
  int checks = 0, errors = 0, cyc = 0;
  int we_cnt0 = 0, done_cnt0 = 0, we_cnt1 = 0, done_cnt1 = 0;
  int last_we_cyc0 = 0, done_cyc0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we0) begin
      we_cnt0++;
      last_we_cyc0 = cyc;
      chk("we0_not_ready", 32'(in_ready0), 32'd0);
      if (q0.size() == 0) fail("unexpected_write0");
      else begin
        e = q0.pop_front();
        chk("wr0_addr", mem_addr0, e.addr);
        chk("wr0_data", mem_data0, e.data);
      end
    end
    if (done0) begin
      done_cnt0++;
      done_cyc0 = cyc;
    end
    if (mem_we1) begin
      we_cnt1++;
      if (q1.size() == 0) fail("unexpected_write1");
      else begin
        e = q1.pop_front();
        chk("wr1_addr", mem_addr1, e.addr);
        chk("wr1_data", mem_data1, e.data);
      end
    end
    if (done1) done_cnt1++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (in_ready0) break;
      n++;
    end
    if (n == 100) fail("byte_accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(t[31:24], gap);
      t = t << 8;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_load(input logic [15:0] cnt, input int gap, input int nwords);
    int n;
    pulse_start();
    chk("start_busy", 32'(busy0), 32'd1);
    chk("start_hold", 32'(cpu_hold0), 32'd1);
    chk("start_err_clr", 32'(error0), 32'd0);
    chk("start_ready", 32'(in_ready0), 32'd1);
    send_byte(cnt[15:8], gap);
    send_byte(cnt[7:0], gap);
    for (int i = 0; i < nwords; i++) begin
      q0.push_back('{addr: BASE0 + 32'(4 * i), data: wd[i % 4]});
      if (en1) q1.push_back('{addr: BASE1 + 32'(4 * i), data: wd[i % 4]});
      send_word(wd[i % 4], gap);
    end
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy0) break;
      n++;
    end
    if (n == 200) fail("load_end_timeout");
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench watchdog");
  end

  initial begin
    int d0, w0, d1, w1, nw;
    wd[0] = 32'hDEADBEEF; wd[1] = 32'h01234567;
    wd[2] = 32'h89ABCDEF; wd[3] = 32'hCAFEF00D;
    vecs[0] = '{cnt: 16'd2,    gap: 0, exp_done: 1, exp_err: 1'b0};
    vecs[1] = '{cnt: 16'd2,    gap: 3, exp_done: 1, exp_err: 1'b0};
    vecs[2] = '{cnt: 16'd0,    gap: 0, exp_done: 1, exp_err: 1'b0};
    vecs[3] = '{cnt: 16'h0401, gap: 0, exp_done: 0, exp_err: 1'b1};
    vecs[4] = '{cnt: 16'd1,    gap: 1, exp_done: 1, exp_err: 1'b0};
    vecs[5] = '{cnt: 16'd3,    gap: 2, exp_done: 1, exp_err: 1'b0};

    reset_n = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_byte = 8'd0; en1 = 1'b0;
    #1 reset_n = 1'b0;
    #11;
    chk("rst_ready", 32'(in_ready0), 32'd0);
    chk("rst_we", 32'(mem_we0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_hold", 32'(cpu_hold0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(error0), 32'd0);
    chk("rst_addr0", mem_addr0, BASE0);
    chk("rst_data0", mem_data0, 32'd0);
    chk("rst_addr1", mem_addr1, BASE1);
    @(negedge clk) reset_n = 1'b1;

    // Table-driven loads.
    for (int i = 0; i < 6; i++) begin
      nw = (vecs[i].cnt <= 16'd1024) ? int'(vecs[i].cnt) : 0;
      d0 = done_cnt0;
      w0 = we_cnt0;
      run_load(vecs[i].cnt, vecs[i].gap, nw);
      chk("vec_done", 32'(done_cnt0 - d0), 32'(vecs[i].exp_done));
      chk("vec_writes", 32'(we_cnt0 - w0), 32'(nw));
      chk("vec_error", 32'(error0), 32'(vecs[i].exp_err));
      chk("vec_idle", 32'(busy0), 32'd0);
      chk("vec_hold_low", 32'(cpu_hold0), 32'd0);
      chk("vec_pending", 32'(q0.size()), 32'd0);
      if (nw > 0) chk("done_after_write", 32'(done_cyc0), 32'(last_we_cyc0 + 1));
    end

    // Abort after two bytes of word 1 of a 3-word load.
    d0 = done_cnt0;
    w0 = we_cnt0;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    q0.push_back('{addr: BASE0, data: wd[0]});
    send_word(wd[0], 0);
    send_byte(wd[1][31:24], 0);
    send_byte(wd[1][23:16], 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_hold", 32'(cpu_hold0), 32'd0);
    chk("abort_ready", 32'(in_ready0), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_done", 32'(done_cnt0 - d0), 32'd0);
    chk("abort_writes", 32'(we_cnt0 - w0), 32'd1);
    chk("abort_addr", mem_addr0, BASE0 + 32'd4);
    chk("abort_data", mem_data0, wd[0]);
    chk("abort_err", 32'(error0), 32'd0);

    // Asynchronous reset mid-DATA, away from any clock edge.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(wd[2][31:24], 0);
    send_byte(wd[2][23:16], 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_hold", 32'(cpu_hold0), 32'd0);
    chk("arst_ready", 32'(in_ready0), 32'd0);
    chk("arst_we", 32'(mem_we0), 32'd0);
    chk("arst_addr", mem_addr0, BASE0);
    chk("arst_data", mem_data0, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    d0 = done_cnt0;
    w0 = we_cnt0;
    run_load(16'd2, 0, 2);
    chk("post_rst_writes", 32'(we_cnt0 - w0), 32'd2);
    chk("post_rst_done", 32'(done_cnt0 - d0), 32'd1);
    chk("post_rst_pending", 32'(q0.size()), 32'd0);

    // Address wrap on the instance based at 0xFFFFFFFC.
    en1 = 1'b1;
    d1 = done_cnt1;
    w1 = we_cnt1;
    run_load(16'd2, 1, 2);
    en1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_writes", 32'(we_cnt1 - w1), 32'd2);
    chk("wrap_done", 32'(done_cnt1 - d1), 32'd1);
    chk("wrap_pending", 32'(q1.size()), 32'd0);
    chk("wrap_addr_end", mem_addr1, 32'h0000_0004);
    chk("wrap_idle", 32'(busy1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
